// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, op encodings and state enum for the multiply/divide unit
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE,
    S_DZ
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed Booth multiplier / restoring divider with HI/LO result
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             md_start,
  input  logic             md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             md_busy,
  output logic             md_done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q;
  // acc_q is one bit wider so Booth can subtract a multiplicand of -2^31 without overflow
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH+1:0] booth_d;

  always_comb begin
    m_ext     = {m_q[WIDTH-1], m_q};
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_d = $signed({booth_sum, q_q, qm1_q}) >>> 1;
  end

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;

  always_comb begin
    rem_sh = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, m_q};
    if (trial[WIDTH]) begin
      rem_d = rem_sh;
      quo_d = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = trial;
      quo_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  always_comb begin
    a_mag   = a[WIDTH-1] ? -a : a;
    b_mag   = b[WIDTH-1] ? -b : b;
    fix_quo = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
    fix_rem = a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md_start) begin
            cnt_q   <= '0;
            a_neg_q <= a[WIDTH-1];
            b_neg_q <= b[WIDTH-1];
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            if (md_op == MD_MULT) begin
              q_q     <= b;
              m_q     <= a;
              busy_q  <= 1'b1;
              state_q <= S_MULT;
            end else if (b == '0) begin
              div0_q  <= 1'b1;
              state_q <= S_DZ;
            end else begin
              q_q     <= a_mag;
              m_q     <= b_mag;
              busy_q  <= 1'b1;
              state_q <= S_DIV;
            end
          end
        end
        S_MULT: begin
          acc_q <= booth_d[2*WIDTH+1:WIDTH+1];
          q_q   <= booth_d[WIDTH:1];
          qm1_q <= booth_d[0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            hi_q    <= booth_d[2*WIDTH:WIDTH+1];
            lo_q    <= booth_d[WIDTH:1];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DIV: begin
          acc_q <= rem_d;
          q_q   <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITERS - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_rem;
          lo_q    <= fix_quo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        S_DZ:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign div0    = div0_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WINDOW = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        md_start;
  logic        md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_busy;
  logic        md_done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  muldiv_unit dut (
    .clock   (clock),
    .reset   (reset),
    .md_start(md_start),
    .md_op   (md_op),
    .a       (a),
    .b       (b),
    .md_busy (md_busy),
    .md_done (md_done),
    .div0    (div0),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Signed product / truncating quotient and remainder from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (op == MD_MULT) return 64'(sa * sb);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input logic op, input logic [31:0] av, input logic [31:0] bv,
                        input int inj_cyc, input int rst_cyc,
                        output int done_cyc, output int done_cnt, output int dz_cyc, output int dz_cnt,
                        output int busy_cnt, output int both_cnt, output logic [66:0] snap);
    done_cyc = -1; done_cnt = 0; dz_cyc = -1; dz_cnt = 0;
    busy_cnt = 0; both_cnt = 0; snap = '1;
    @(negedge clock);
    md_start = 1'b1; md_op = op; a = av; b = bv;
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge clock);
      md_start = 1'b0;
      reset = 1'b0;
      if (k == inj_cyc) begin
        md_start = 1'b1; md_op = MD_DIV; a = 32'h5; b = 32'h0;
      end
      if (k == rst_cyc) reset = 1'b1;
      if (md_done) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
      if (div0) begin dz_cnt++; if (dz_cyc < 0) dz_cyc = k; end
      if (md_busy) busy_cnt++;
      if (md_done && div0) both_cnt++;
      if (k == rst_cyc + 1) snap = {md_busy, md_done, div0, hi, lo};
    end
  endtask

  int          dc, dn, zc, zn, bc, bb, both_total;
  logic [66:0] snap;
  logic [63:0] exp_r;
  logic [31:0] mdl_hi, mdl_lo, av, bv;
  logic        op;

  initial begin
    reset = 1'b1; md_start = 1'b0; md_op = 1'b0; a = '0; b = '0;
    both_total = 0;
    vecs[0] = '{MD_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{MD_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{MD_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[5] = '{MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{MD_DIV,  32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022};

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_outputs", {md_busy, md_done, div0, hi, lo}, 67'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, dc, dn, zc, zn, bc, bb, snap);
      check($sformatf("vec%0d_hi", i), 67'(hi), 67'(vecs[i].ehi));
      check($sformatf("vec%0d_lo", i), 67'(lo), 67'(vecs[i].elo));
      check($sformatf("vec%0d_done_cycle", i), 67'(dc), vecs[i].op ? 67'd34 : 67'd33);
      check($sformatf("vec%0d_done_count", i), 67'(dn), 67'd1);
      check($sformatf("vec%0d_busy_cycles", i), 67'(bc), vecs[i].op ? 67'd33 : 67'd32);
      check($sformatf("vec%0d_div0_count", i), 67'(zn), 67'd0);
      both_total += bb;
    end

    // Divide by zero after a 0x11/0x22 result must leave HI/LO alone
    run_op(MD_DIV, 32'h1234, 32'h0, 0, 0, dc, dn, zc, zn, bc, bb, snap);
    check("dz_div0_cycle", 67'(zc), 67'd1);
    check("dz_div0_count", 67'(zn), 67'd1);
    check("dz_no_done", 67'(dn), 67'd0);
    check("dz_busy_cycles", 67'(bc), 67'd0);
    check("dz_hi_held", 67'(hi), 67'h11);
    check("dz_lo_held", 67'(lo), 67'h22);

    // A DIV-by-zero start during MULT must be ignored entirely
    exp_r = ref_result(MD_MULT, 32'h00012345, 32'hFEDCBA98);
    run_op(MD_MULT, 32'h00012345, 32'hFEDCBA98, 5, 0, dc, dn, zc, zn, bc, bb, snap);
    check("inj_done_cycle", 67'(dc), 67'd33);
    check("inj_done_count", 67'(dn), 67'd1);
    check("inj_div0_count", 67'(zn), 67'd0);
    check("inj_result", 67'({hi, lo}), 67'(exp_r));

    // Reset in the middle of a DIV
    run_op(MD_DIV, 32'h7FFFFFFF, 32'h3, 0, 10, dc, dn, zc, zn, bc, bb, snap);
    check("rst_cycle11_outputs", snap, 67'd0);
    check("rst_no_done", 67'(dn), 67'd0);
    check("rst_no_div0", 67'(zn), 67'd0);
    check("rst_hilo_end", 67'({hi, lo}), 67'd0);

    mdl_hi = '0; mdl_lo = '0;
    for (int n = 0; n < 40; n++) begin
      op = 1'($urandom_range(0, 1));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 7))
        0: bv = 32'h0;
        1: bv = 32'($urandom_range(1, 15));
        2: bv = 32'hFFFFFFFF;
        3: av = 32'h80000000;
        default: ;
      endcase
      run_op(op, av, bv, 0, 0, dc, dn, zc, zn, bc, bb, snap);
      both_total += bb;
      if (op == MD_DIV && bv == 32'h0) begin
        check($sformatf("rnd%0d_div0_cycle", n), 67'(zc), 67'd1);
        check($sformatf("rnd%0d_done_count", n), 67'(dn), 67'd0);
      end else begin
        exp_r = ref_result(op, av, bv);
        mdl_hi = exp_r[63:32];
        mdl_lo = exp_r[31:0];
        check($sformatf("rnd%0d_done_cycle", n), 67'(dc), op ? 67'd34 : 67'd33);
        check($sformatf("rnd%0d_div0_count", n), 67'(zn), 67'd0);
      end
      check($sformatf("rnd%0d_hi", n), 67'(hi), 67'(mdl_hi));
      check($sformatf("rnd%0d_lo", n), 67'(lo), 67'(mdl_lo));
    end

    check("done_div0_overlap", 67'(both_total), 67'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
